broadcast_engine: RTL and testbench

- Downstream consumer of the reduction engine's per-row results.
- For each of outer_count rows, reads one INT8 scalar (e.g. row max or mean) and applies it elementwise across inner_dim INT8 elements with ADD, SUB or MUL. Writes saturated INT8 results back to SRAM0.
- Serves softmax (x - max) and layernorm (x - mean) graph ops.
- Sits beside the reduce stage on SRAM0, sequenced by the graph dispatcher.

---
 rtl/graph_isa_pkg.sv | 12 +
 rtl/bcast_alu.sv | 60 ++++++
 rtl/broadcast_engine.sv | 209 ++++++++++++++++++++
 tb/tb_broadcast_engine.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/graph_isa_pkg.sv
// Graph ISA constants shared by the graph-op engines.
// Holds the broadcast opcodes consumed by broadcast_engine and bcast_alu.
package graph_isa_pkg;

    localparam logic [7:0] OP_G_BCAST_ADD = 8'h30;
    localparam logic [7:0] OP_G_BCAST_SUB = 8'h31;
    localparam logic [7:0] OP_G_BCAST_MUL = 8'h32;

    localparam logic signed [17:0] SAT_HI = 18'sd127;
    localparam logic signed [17:0] SAT_LO = -18'sd128;

endpackage

// File: rtl/bcast_alu.sv
// Combinational INT8 elementwise ALU: ADD/SUB/MUL-with-rounding-shift,
// saturated to INT8 with an out-of-range flag. Unknown opcodes copy x.
module bcast_alu
    import graph_isa_pkg::*;
(
    input  logic [7:0] opcode_i,
    input  logic [7:0] x_i,
    input  logic [7:0] s_i,
    input  logic [3:0] shift_i,
    output logic [7:0] result_o,
    output logic       sat_o
);

    logic signed [15:0] x16;
    logic signed [15:0] s16;
    logic signed [15:0] prod;
    logic signed [17:0] prod_w;
    logic signed [17:0] rnd;
    logic signed [17:0] wide;
    logic               pass;

    assign x16    = {{8{x_i[7]}}, x_i};
    assign s16    = {{8{s_i[7]}}, s_i};
    assign prod   = x16 * s16;
    assign prod_w = {{2{prod[15]}}, prod};

    // Rounding term is added in 18 bits so -128*-128 plus bias cannot wrap
    always_comb begin
        rnd = '0;
        if (shift_i != 4'd0) begin
            rnd = 18'sd1 <<< (shift_i - 4'd1);
        end
    end

    always_comb begin
        pass = 1'b0;
        case (opcode_i)
            OP_G_BCAST_ADD: wide = {{10{x_i[7]}}, x_i} + {{10{s_i[7]}}, s_i};
            OP_G_BCAST_SUB: wide = {{10{x_i[7]}}, x_i} - {{10{s_i[7]}}, s_i};
            OP_G_BCAST_MUL: wide = (prod_w + rnd) >>> shift_i;
            default: begin
                wide = {{10{x_i[7]}}, x_i};
                pass = 1'b1;
            end
        endcase
    end

    always_comb begin
        result_o = wide[7:0];
        sat_o    = 1'b0;
        if (!pass && wide > SAT_HI) begin
            result_o = 8'h7F;
            sat_o    = 1'b1;
        end else if (!pass && wide < SAT_LO) begin
            result_o = 8'h80;
            sat_o    = 1'b1;
        end
    end

endmodule

// File: rtl/broadcast_engine.sv
// Per-row scalar broadcast (ADD/SUB/MUL) over an INT8 matrix in SRAM0.
// Define BCAST_SAT_CNT_EN to add the sat_count saturation counter output.
module broadcast_engine
    import graph_isa_pkg::*;
#(
    parameter int SRAM0_AW = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [7:0]          cmd_opcode,
    input  logic [15:0]         cmd_src_base,
    input  logic [15:0]         cmd_scalar_base,
    input  logic [15:0]         cmd_dst_base,
    input  logic [15:0]         cmd_inner_dim,
    input  logic [15:0]         cmd_outer_count,
    input  logic [3:0]          cmd_shift,
    output logic                sram_rd_en,
    output logic [SRAM0_AW-1:0] sram_rd_addr,
    input  logic [7:0]          sram_rd_data,
    output logic                sram_wr_en,
    output logic [SRAM0_AW-1:0] sram_wr_addr,
    output logic [7:0]          sram_wr_data,
    output logic                busy,
    output logic                done
`ifdef BCAST_SAT_CNT_EN
    ,
    output logic [15:0]         sat_count
`endif
);

    typedef enum logic [2:0] {
        BE_IDLE,
        BE_ROW_INIT,
        BE_SCALAR,
        BE_STREAM,
        BE_NEXT_ROW,
        BE_DONE
    } be_state_t;

    be_state_t   state_q, state_d;
    logic [7:0]  op_q, op_d;
    logic [15:0] src_q, src_d;
    logic [15:0] scl_q, scl_d;
    logic [15:0] dst_q, dst_d;
    logic [15:0] inner_q, inner_d;
    logic [15:0] outer_q, outer_d;
    logic [3:0]  shift_q, shift_d;
    logic [15:0] row_q, row_d;
    logic [15:0] roff_q, roff_d;
    logic [15:0] k_q, k_d;
    logic [7:0]  s_q, s_d;

    logic [7:0]  alu_res;
    logic        alu_sat;
    logic        more;

    bcast_alu u_alu (
        .opcode_i (op_q),
        .x_i      (sram_rd_data),
        .s_i      (s_q),
        .shift_i  (shift_q),
        .result_o (alu_res),
        .sat_o    (alu_sat)
    );

    assign more = ({1'b0, k_q} + 17'd1) < {1'b0, inner_q};

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        src_d        = src_q;
        scl_d        = scl_q;
        dst_d        = dst_q;
        inner_d      = inner_q;
        outer_d      = outer_q;
        shift_d      = shift_q;
        row_d        = row_q;
        roff_d       = roff_q;
        k_d          = k_q;
        s_d          = s_q;
        cmd_ready    = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        sram_rd_en   = 1'b0;
        sram_rd_addr = '0;
        sram_wr_en   = 1'b0;
        sram_wr_addr = '0;
        sram_wr_data = '0;
        case (state_q)
            BE_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    op_d    = cmd_opcode;
                    src_d   = cmd_src_base;
                    scl_d   = cmd_scalar_base;
                    dst_d   = cmd_dst_base;
                    inner_d = cmd_inner_dim;
                    outer_d = cmd_outer_count;
                    shift_d = cmd_shift;
                    row_d   = '0;
                    roff_d  = '0;
                    k_d     = '0;
                    if (cmd_inner_dim == '0 || cmd_outer_count == '0) begin
                        state_d = BE_DONE;
                    end else begin
                        state_d = BE_ROW_INIT;
                    end
                end
            end
            BE_ROW_INIT: begin
                sram_rd_en   = 1'b1;
                sram_rd_addr = SRAM0_AW'(scl_q + row_q);
                state_d      = BE_SCALAR;
            end
            BE_SCALAR: begin
                s_d          = sram_rd_data;
                sram_rd_en   = 1'b1;
                sram_rd_addr = SRAM0_AW'(src_q + roff_q);
                k_d          = '0;
                state_d      = BE_STREAM;
            end
            BE_STREAM: begin
                // Write k and read k+1 together; k+1 is never an earlier write
                sram_wr_en   = 1'b1;
                sram_wr_addr = SRAM0_AW'(dst_q + roff_q + k_q);
                sram_wr_data = alu_res;
                if (more) begin
                    sram_rd_en   = 1'b1;
                    sram_rd_addr = SRAM0_AW'(src_q + roff_q + k_q + 16'd1);
                    k_d          = k_q + 16'd1;
                end else begin
                    state_d = BE_NEXT_ROW;
                end
            end
            BE_NEXT_ROW: begin
                row_d  = row_q + 16'd1;
                roff_d = roff_q + inner_q;
                if (row_q == outer_q - 16'd1) begin
                    state_d = BE_DONE;
                end else begin
                    state_d = BE_ROW_INIT;
                end
            end
            BE_DONE: begin
                done    = 1'b1;
                state_d = BE_IDLE;
            end
            default: state_d = BE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BE_IDLE;
            op_q    <= '0;
            src_q   <= '0;
            scl_q   <= '0;
            dst_q   <= '0;
            inner_q <= '0;
            outer_q <= '0;
            shift_q <= '0;
            row_q   <= '0;
            roff_q  <= '0;
            k_q     <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            src_q   <= src_d;
            scl_q   <= scl_d;
            dst_q   <= dst_d;
            inner_q <= inner_d;
            outer_q <= outer_d;
            shift_q <= shift_d;
            row_q   <= row_d;
            roff_q  <= roff_d;
            k_q     <= k_d;
            s_q     <= s_d;
        end
    end

`ifdef BCAST_SAT_CNT_EN
    logic [15:0] sat_cnt_q, sat_cnt_d;

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (state_q == BE_IDLE && cmd_valid) begin
            sat_cnt_d = '0;
        end else if (state_q == BE_STREAM && alu_sat
                     && sat_cnt_q != 16'hFFFF) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_count = sat_cnt_q;
`endif

endmodule

// File: tb/tb_broadcast_engine.sv
// Directed testbench for broadcast_engine with a one-cycle-latency SRAM0 model.
// Table-driven ALU vectors plus hand sequences for latency, in-place and reset.
module tb_broadcast_engine;
    import graph_isa_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_opcode;
    logic [15:0] cmd_src_base;
    logic [15:0] cmd_scalar_base;
    logic [15:0] cmd_dst_base;
    logic [15:0] cmd_inner_dim;
    logic [15:0] cmd_outer_count;
    logic [3:0]  cmd_shift;
    logic        sram_rd_en;
    logic [15:0] sram_rd_addr;
    logic [7:0]  sram_rd_data;
    logic        sram_wr_en;
    logic [15:0] sram_wr_addr;
    logic [7:0]  sram_wr_data;
    logic        busy;
    logic        done;
`ifdef BCAST_SAT_CNT_EN
    logic [15:0] sat_count;
`endif

    always #5 clk = ~clk;

    broadcast_engine #(.SRAM0_AW(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_opcode      (cmd_opcode),
        .cmd_src_base    (cmd_src_base),
        .cmd_scalar_base (cmd_scalar_base),
        .cmd_dst_base    (cmd_dst_base),
        .cmd_inner_dim   (cmd_inner_dim),
        .cmd_outer_count (cmd_outer_count),
        .cmd_shift       (cmd_shift),
        .sram_rd_en      (sram_rd_en),
        .sram_rd_addr    (sram_rd_addr),
        .sram_rd_data    (sram_rd_data),
        .sram_wr_en      (sram_wr_en),
        .sram_wr_addr    (sram_wr_addr),
        .sram_wr_data    (sram_wr_data),
        .busy            (busy),
        .done            (done)
`ifdef BCAST_SAT_CNT_EN
        ,
        .sat_count       (sat_count)
`endif
    );

    logic [7:0]  mem [0:65535];
    logic        poke_en = 1'b0;
    logic [15:0] poke_addr = '0;
    logic [7:0]  poke_data = '0;

    always @(posedge clk) begin
        if (sram_rd_en) sram_rd_data <= mem[sram_rd_addr];
        if (sram_wr_en) mem[sram_wr_addr] <= sram_wr_data;
        if (poke_en) mem[poke_addr] <= poke_data;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int rd_cnt  = 0;
    int wr_cnt  = 0;
    int done_cnt = 0;
    int hazard  = 0;
    logic [15:0] wq[$];

    always @(negedge clk) begin
        if (sram_rd_en) begin
            rd_cnt++;
            foreach (wq[i]) if (wq[i] == sram_rd_addr) hazard++;
        end
        if (sram_wr_en) begin
            wr_cnt++;
            wq.push_back(sram_wr_addr);
        end
        if (done) done_cnt++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input int v);
        poke_addr = a;
        poke_data = 8'(v);
        poke_en   = 1'b1;
        @(negedge clk);
        poke_en   = 1'b0;
    endtask

    function automatic int rdm(input logic [15:0] a);
        return int'($signed(mem[a]));
    endfunction

    function automatic int sat8(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    task automatic start_cmd(input logic [7:0] op, input logic [15:0] src,
                             input logic [15:0] scl, input logic [15:0] dst,
                             input int inner, input int outer, input int sh);
        cmd_opcode      = op;
        cmd_src_base    = src;
        cmd_scalar_base = scl;
        cmd_dst_base    = dst;
        cmd_inner_dim   = 16'(inner);
        cmd_outer_count = 16'(outer);
        cmd_shift       = 4'(sh);
        cmd_valid       = 1'b1;
        @(negedge clk);
        cmd_valid       = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int cyc);
        cyc = c0;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) chk("done_timeout", 0, 1);
        @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] op;
        int         sh;
        int         x;
        int         s;
        int         exp;
    } vec_t;

    vec_t vec [10];

    initial begin
        int cyc;
        int r0;
        int w0;
        int d0;
        int orig [24];
        int scl3 [3];

        vec[0] = '{OP_G_BCAST_ADD, 0, 3, 4, 7};
        vec[1] = '{OP_G_BCAST_ADD, 0, 100, 100, 127};
        vec[2] = '{OP_G_BCAST_ADD, 0, -100, -100, -128};
        vec[3] = '{OP_G_BCAST_SUB, 0, 10, 20, -10};
        vec[4] = '{OP_G_BCAST_SUB, 0, -128, 1, -128};
        vec[5] = '{OP_G_BCAST_MUL, 3, 50, 10, 63};
        vec[6] = '{OP_G_BCAST_MUL, 3, -50, 10, -62};
        vec[7] = '{OP_G_BCAST_MUL, 0, 20, 20, 127};
        vec[8] = '{OP_G_BCAST_MUL, 1, -3, 1, -1};
        vec[9] = '{8'hFF, 0, -7, 55, -7};

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_opcode = '0;
        cmd_src_base = '0;
        cmd_scalar_base = '0;
        cmd_dst_base = '0;
        cmd_inner_dim = '0;
        cmd_outer_count = '0;
        cmd_shift = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rd_en", int'(sram_rd_en), 0);
        chk("rst_wr_en", int'(sram_wr_en), 0);
`ifdef BCAST_SAT_CNT_EN
        chk("rst_sat_count", int'(sat_count), 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // ALU vectors as single-element commands
        for (int i = 0; i < 10; i++) begin
            poke(16'h0100, vec[i].x);
            poke(16'h0200, vec[i].s);
            start_cmd(vec[i].op, 16'h0100, 16'h0200, 16'h0300, 1, 1, vec[i].sh);
            wait_done(1, cyc);
            chk($sformatf("vec%0d_res", i), rdm(16'h0300), vec[i].exp);
            chk($sformatf("vec%0d_lat", i), cyc, 5);
        end

        // Two-row matrix SUB with latency and single done pulse
        poke(16'h1000, 10);   poke(16'h1001, 20);
        poke(16'h1002, -5);   poke(16'h1003, 127);
        poke(16'h1004, -128); poke(16'h1005, 0);
        poke(16'h1006, 1);    poke(16'h1007, 2);
        poke(16'h2000, 20);   poke(16'h2001, -1);
        d0 = done_cnt;
        start_cmd(OP_G_BCAST_SUB, 16'h1000, 16'h2000, 16'h3000, 4, 2, 0);
        wait_done(1, cyc);
        chk("t1_latency", cyc, 15);
        chk("t1_done_pulses", done_cnt - d0, 1);
        chk("t1_r0e0", rdm(16'h3000), -10);
        chk("t1_r0e1", rdm(16'h3001), 0);
        chk("t1_r0e2", rdm(16'h3002), -25);
        chk("t1_r0e3", rdm(16'h3003), 107);
        chk("t1_r1e0", rdm(16'h3004), -127);
        chk("t1_r1e1", rdm(16'h3005), 1);
        chk("t1_r1e2", rdm(16'h3006), 2);
        chk("t1_r1e3", rdm(16'h3007), 3);

        // ADD saturation in both directions, one element per row
        poke(16'h1100, 100);  poke(16'h1101, -100);
        poke(16'h2100, 100);  poke(16'h2101, -100);
        start_cmd(OP_G_BCAST_ADD, 16'h1100, 16'h2100, 16'h3300, 1, 2, 0);
        wait_done(1, cyc);
        chk("t2_pos_sat", rdm(16'h3300), 127);
        chk("t2_neg_sat", rdm(16'h3301), -128);
        chk("t2_latency", cyc, 9);
`ifdef BCAST_SAT_CNT_EN
        chk("t2_sat_count", int'(sat_count), 2);
`endif

        // In-place SUB, 3 rows of 8
        scl3[0] = 5; scl3[1] = -3; scl3[2] = 100;
        for (int i = 0; i < 24; i++) begin
            orig[i] = int'($signed(8'(i * 11 - 120)));
            poke(16'(16'h4000 + i), orig[i]);
        end
        for (int r = 0; r < 3; r++) poke(16'(16'h5000 + r), scl3[r]);
        wq.delete();
        hazard = 0;
        start_cmd(OP_G_BCAST_SUB, 16'h4000, 16'h5000, 16'h4000, 8, 3, 0);
        wait_done(1, cyc);
        chk("t4_latency", cyc, 34);
        chk("t4_hazard", hazard, 0);
        for (int i = 0; i < 24; i++) begin
            chk($sformatf("t4_e%0d", i), rdm(16'(16'h4000 + i)),
                sat8(orig[i] - scl3[i / 8]));
        end

        // Degenerate sizes: no SRAM traffic, done in first cycle
        r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt;
        start_cmd(OP_G_BCAST_ADD, 16'h1000, 16'h2000, 16'h6000, 4, 0, 0);
        wait_done(1, cyc);
        chk("t5_outer0_lat", cyc, 1);
        start_cmd(OP_G_BCAST_ADD, 16'h1000, 16'h2000, 16'h6000, 0, 3, 0);
        wait_done(1, cyc);
        chk("t5_inner0_lat", cyc, 1);
        chk("t5_no_rd", rd_cnt - r0, 0);
        chk("t5_no_wr", wr_cnt - w0, 0);
        chk("t5_done_pulses", done_cnt - d0, 2);

        // cmd_valid while busy is dropped
        poke(16'h7000, 8'h55);
        poke(16'h7001, 8'h55);
        d0 = done_cnt;
        start_cmd(OP_G_BCAST_SUB, 16'h1000, 16'h2000, 16'h6100, 2, 1, 0);
        cmd_opcode   = OP_G_BCAST_ADD;
        cmd_dst_base = 16'h7000;
        cmd_valid    = 1'b1;
        repeat (2) @(negedge clk);
        cmd_valid    = 1'b0;
        wait_done(3, cyc);
        chk("t5_busy_lat", cyc, 6);
        repeat (8) @(negedge clk);
        chk("t5_busy_pulses", done_cnt - d0, 1);
        chk("t5_busy_dst0", rdm(16'h6100), -10);
        chk("t5_busy_ignored", rdm(16'h7000), 85);

        // Reset mid-row aborts, then a fresh command runs cleanly
        start_cmd(OP_G_BCAST_SUB, 16'h1000, 16'h2000, 16'h3100, 4, 2, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_busy", int'(busy), 0);
        chk("t6_ready", int'(cmd_ready), 1);
        chk("t6_wr_en", int'(sram_wr_en), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_post_rd", int'(sram_rd_en), 0);
        chk("t6_post_wr", int'(sram_wr_en), 0);
        start_cmd(OP_G_BCAST_SUB, 16'h1000, 16'h2000, 16'h3200, 4, 2, 0);
        wait_done(1, cyc);
        chk("t6_latency", cyc, 15);
        chk("t6_r0e0", rdm(16'h3200), -10);
        chk("t6_r0e3", rdm(16'h3203), 107);
        chk("t6_r1e0", rdm(16'h3204), -127);
        chk("t6_r1e3", rdm(16'h3207), 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
